sa_stream_controller: RTL and testbench

SA_STREAM_CONTROLLER -- requirements
Module: sa_stream_controller

---
 rtl/sa_stream_controller.sv | 116 +++++++++++
 tb/tb_sa_stream_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sa_stream_controller.sv
// sa_stream_controller: skews activation vectors into a fixed-weight systolic
// array, deskews its column outputs and buffers results in a credit-guarded FIFO.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data (vector in);
//   sa_inputs/sa_outputs/sa_resetn (array side); out_valid/out_ready/out_data
//   (result out); busy (vector in flight or FIFO non-empty).
module sa_stream_controller #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] in_data,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_inputs,
  output logic                                    sa_resetn,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] sa_outputs,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] out_data,
  output logic                                    busy
);
  localparam int N    = SA_SIZE;
  localparam int W    = ACTIVATION_SIZE;
  localparam int TAGS = 2*N-2;
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic          accept;
  logic          push;
  logic          pop;
  logic [TAGS-1:0] tag;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits;
  vec_t          aligned;
  vec_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // The array shares our reset cycle.
  assign sa_resetn = ~reset;

  // Credits cover both queued results and tagged vectors still in the
  // array, so a push can never land on a full FIFO.
  assign credits   = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready  = ~reset & (credits < (CW+1)'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = tag[TAGS-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (inflight != '0) | out_valid;
  assign out_data  = mem[rd_ptr];

  // Row 0 enters directly; idle cycles inject zero bubbles.
  assign sa_inputs[0] = accept ? in_data[0] : '0;

  for (genvar r = 1; r < N; r++) begin : g_skew
    logic [W-1:0] sk [r];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < r; k++) sk[k] <= '0;
      end else begin
        sk[0] <= accept ? in_data[r] : '0;
        for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
      end
    end
    assign sa_inputs[r] = sk[r-1];
  end

  // Earlier columns emerge earlier; delay them to line up with the last.
  assign aligned[N-1] = sa_outputs[N-1];

  for (genvar c = 0; c < N-1; c++) begin : g_deskew
    localparam int D = N-1-c;
    logic [W-1:0] dk [D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < D; k++) dk[k] <= '0;
      end else begin
        dk[0] <= sa_outputs[c];
        for (int k = 1; k < D; k++) dk[k] <= dk[k-1];
      end
    end
    assign aligned[c] = dk[D-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag        <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      tag        <= {tag[TAGS-2:0], accept};
      inflight   <= inflight + CW'(accept) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // Storage needs no reset: out_valid masks it until a real push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= aligned;
  end

endmodule

// File: tb/tb_sa_stream_controller.sv
// tb_sa_stream_controller: randomized bench for sa_stream_controller with a
// pass-through array model and a cycle-level queue reference model.
module tb_sa_stream_controller;
  localparam int S    = 8;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int TAGS = 2*S-2;
  localparam int MAXC = 4096;

  typedef logic [S-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic sa_resetn;
  logic out_valid;
  logic out_ready;
  logic busy;
  vec_t in_data;
  vec_t sa_inputs;
  vec_t sa_outputs;
  vec_t out_data;
  vec_t hist [S-1];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   acc_v [MAXC];
  vec_t acc_d [MAXC];
  vec_t q [$];

  always #5 clk = ~clk;

  sa_stream_controller #(
    .SA_SIZE(S),
    .ACTIVATION_SIZE(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .sa_inputs(sa_inputs),
    .sa_resetn(sa_resetn),
    .sa_outputs(sa_outputs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  // Identity array: column c repeats row c, S-1 cycles later.
  always @(posedge clk) begin
    if (!sa_resetn) begin
      for (int k = 0; k < S-1; k++) hist[k] <= '0;
    end else begin
      hist[0] <= sa_inputs;
      for (int k = 1; k < S-1; k++) hist[k] <= hist[k-1];
    end
  end
  assign sa_outputs = hist[S-2];

  task automatic check(input string tag, input logic [S*W-1:0] got,
                       input logic [S*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Vectors accepted in the last TAGS cycles are still in the pipeline.
  function automatic int inflight_m();
    int n = 0;
    for (int k = 1; k <= TAGS; k++)
      if (cyc - k >= 0 && acc_v[cyc-k]) n++;
    return n;
  endfunction

  function automatic vec_t exp_sa_in();
    vec_t v = '0;
    for (int r = 0; r < S; r++)
      if (cyc - r >= 0 && acc_v[cyc-r]) v[r] = acc_d[cyc-r][r];
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    return vec_t'({$urandom(), $urandom()});
  endfunction

  task automatic step(input bit rst, input bit iv, input vec_t d,
                      input bit ordy);
    int infl;
    bit rdy;
    reset     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    infl      = inflight_m();
    rdy       = !rst && (infl + q.size() < D);
    acc_v[cyc] = rdy && iv;
    acc_d[cyc] = d;
    @(negedge clk);
    check("in_ready", in_ready, rdy);
    check("sa_resetn", sa_resetn, !rst);
    if (!rst) begin
      check("sa_inputs", sa_inputs, exp_sa_in());
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) check("out_data", out_data, q[0]);
      check("busy", busy, infl != 0 || q.size() != 0);
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k <= cyc; k++) acc_v[k] = 1'b0;
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (cyc >= TAGS && acc_v[cyc-TAGS]) q.push_back(acc_d[cyc-TAGS]);
    end
    cyc++;
    #1;
  endtask

  initial begin
    vec_t v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1, 0, '0, 0);

    // Single vector {1..8}, held then drained.
    v = '0;
    for (int r = 0; r < S; r++) v[r] = W'(r + 1);
    step(0, 1, v, 0);
    repeat (17) step(0, 0, '0, 0);
    repeat (3) step(0, 0, '0, 1);

    // Idle: no input ever.
    repeat (30) step(0, 0, '0, $urandom_range(0, 1));

    // Fill to full, one pop, refill, drain.
    repeat (25) step(0, 1, rnd_vec(), 0);
    step(0, 1, rnd_vec(), 1);
    repeat (20) step(0, 1, rnd_vec(), 0);
    repeat (25) step(0, 0, '0, 1);

    // Continuous streaming with a ready consumer.
    repeat (60) step(0, 1, rnd_vec(), 1);
    repeat (20) step(0, 0, '0, 1);

    // Random traffic.
    repeat (500)
      step(0, $urandom_range(0, 3) != 0, rnd_vec(), $urandom_range(0, 2) != 0);

    // Reset with three vectors in flight.
    repeat (20) step(0, 0, '0, 1);
    repeat (3) step(0, 1, rnd_vec(), 0);
    repeat (7) step(0, 0, '0, 0);
    repeat (2) step(1, 1, rnd_vec(), 1);
    repeat (30) step(0, 0, '0, 1);
    repeat (200)
      step(0, $urandom_range(0, 1), rnd_vec(), $urandom_range(0, 1));
    repeat (30) step(0, 0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
